sprite_row_renderer: RTL and testbench

- Parametrised scanline renderer for one horizontal row of N identical scaled sprites.
- Sits between the VGA timing generator and the pixel colour mux.
- Sprites are spaced at a fixed pitch, each individually enabled by a mask.
- The bitmap is runtime-writable and holds two animation frames.
- Emits a registered per-pixel hit flag plus the 1-based index of the sprite being drawn.

---
 rtl/sprite_row_renderer_pkg.sv | 24 ++
 rtl/sprite_row_renderer_bitmap_ram.sv | 39 +++
 rtl/sprite_row_renderer.sv | 213 +++++++++++++++++++++
 tb/tb_sprite_row_renderer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_row_renderer_pkg.sv
// Shared sprite-renderer definitions: FSM encoding and default sprite-row geometry
// used by the invader, player and shield renderers.
package sprite_row_renderer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_AWAIT     = 2'd1,
    ST_DRAW      = 2'd2,
    ST_LINE_WAIT = 2'd3
  } spr_state_t;

  localparam int DEF_N_SPR = 11;
  localparam int DEF_SPR_W = 13;
  localparam int DEF_SPR_H = 8;
  localparam int DEF_SCALE = 2;
  localparam int DEF_PITCH = 32;
  localparam int DEF_X_W   = 10;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_row_renderer_bitmap_ram.sv
// Two-frame sprite bitmap: frame-major line store, synchronous write, asynchronous read.
module sprite_row_renderer_bitmap_ram
  import sprite_row_renderer_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  localparam int ROW_W = cnt_w(SPR_H)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_frame,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [SPR_W-1:0] wr_data,
  input  logic             rd_frame,
  input  logic [ROW_W-1:0] rd_row,
  output logic [SPR_W-1:0] rd_data
);

  localparam int AW = cnt_w(2 * SPR_H);

  logic [SPR_W-1:0] mem [2*SPR_H];
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  // Frame 1 lines sit directly after the SPR_H lines of frame 0.
  function automatic logic [AW-1:0] line_addr(input logic frame, input logic [ROW_W-1:0] row);
    return frame ? (AW'(SPR_H) + AW'(row)) : AW'(row);
  endfunction

  assign wr_addr = line_addr(wr_frame, wr_row);
  assign rd_addr = line_addr(rd_frame, rd_row);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_row_renderer.sv
// Scanline renderer for one row of N_SPR identical scaled sprites at a fixed pitch,
// emitting a registered per-pixel hit flag and 1-based sprite index.
module sprite_row_renderer
  import sprite_row_renderer_pkg::*;
#(
  parameter int N_SPR = DEF_N_SPR,
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  parameter int SCALE = DEF_SCALE,
  parameter int PITCH = DEF_PITCH,
  parameter int X_W   = DEF_X_W,
  localparam int ROW_W = cnt_w(SPR_H),
  localparam int IDX_W = $clog2(N_SPR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [X_W-1:0]   pixel_x,
  input  logic             line_end,
  input  logic             start,
  input  logic [X_W-1:0]   row_x,
  input  logic [N_SPR-1:0] alive,
  input  logic             frame_sel,
  input  logic             wr_en,
  input  logic             wr_frame,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [SPR_W-1:0] wr_data,
  output logic             busy,
  output logic             spr_on,
  output logic [IDX_W-1:0] spr_idx,
  output logic             row_done
);

  localparam int I_W  = cnt_w(N_SPR);
  localparam int XC_W = cnt_w(SPR_W);
  localparam int CX_W = cnt_w(SCALE);
  localparam int PW   = X_W + $clog2(N_SPR) + $clog2(PITCH);

  spr_state_t       state, state_nxt;
  logic [I_W-1:0]   slot, slot_nxt;
  logic [XC_W-1:0]  x_cnt, x_nxt;
  logic [CX_W-1:0]  cx_cnt, cx_nxt;
  logic [ROW_W-1:0] y_cnt, y_nxt;
  logic [CX_W-1:0]  cy_cnt, cy_nxt;

  logic [X_W-1:0]   row_x_q;
  logic [N_SPR-1:0] alive_q;
  logic             frame_q;
  logic             take;

  logic             spr_on_p1, spr_on_nxt;
  logic [IDX_W-1:0] spr_idx_p1, spr_idx_nxt;
  logic             row_done_p1, row_done_nxt;

  logic [SPR_W-1:0] rd_data;
  logic [PW-1:0]    slot_pos;
  logic             slot_hit;
  logic [XC_W-1:0]  x_cur;
  logic [CX_W-1:0]  cx_cur;
  logic             draw_stb;
  logic             pix_bit;
  logic             last_col, last_sub, last_slot, last_y, last_cy;

  sprite_row_renderer_bitmap_ram #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_bitmap (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_frame (wr_frame),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .rd_frame (frame_q),
    .rd_row   (y_cnt),
    .rd_data  (rd_data)
  );

  // Slot origin at full width so positions past the screen edge never alias onto it.
  assign slot_pos = PW'(row_x_q) + PW'(slot) * PW'(PITCH);
  assign slot_hit = pix_en && (slot_pos == PW'(pixel_x));

  // The strobe that matches a slot origin is already pixel 0 of that sprite, which is
  // what lets abutting sprites render without a gap.
  assign x_cur    = (state == ST_DRAW) ? x_cnt  : '0;
  assign cx_cur   = (state == ST_DRAW) ? cx_cnt : '0;
  assign draw_stb = pix_en && !line_end &&
                    ((state == ST_DRAW) || ((state == ST_AWAIT) && slot_hit && alive_q[slot]));
  assign pix_bit  = rd_data[XC_W'(SPR_W - 1) - x_cur];

  assign last_col  = (x_cur == XC_W'(SPR_W - 1));
  assign last_sub  = (cx_cur == CX_W'(SCALE - 1));
  assign last_slot = (slot == I_W'(N_SPR - 1));
  assign last_y    = (y_cnt == ROW_W'(SPR_H - 1));
  assign last_cy   = (cy_cnt == CX_W'(SCALE - 1));

  always_comb begin
    state_nxt    = state;
    slot_nxt     = slot;
    x_nxt        = x_cnt;
    cx_nxt       = cx_cnt;
    y_nxt        = y_cnt;
    cy_nxt       = cy_cnt;
    take         = 1'b0;
    row_done_nxt = 1'b0;
    spr_on_nxt   = spr_on_p1;
    spr_idx_nxt  = spr_idx_p1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          take      = 1'b1;
          state_nxt = ST_AWAIT;
          slot_nxt  = '0;
          x_nxt     = '0;
          cx_nxt    = '0;
          y_nxt     = '0;
          cy_nxt    = '0;
        end
      end
      default: begin
        if (line_end) begin
          slot_nxt = '0;
          x_nxt    = '0;
          cx_nxt   = '0;
          if (last_cy) begin
            cy_nxt = '0;
            if (last_y) begin
              state_nxt    = ST_IDLE;
              row_done_nxt = 1'b1;
              y_nxt        = '0;
            end else begin
              state_nxt = ST_AWAIT;
              y_nxt     = y_cnt + ROW_W'(1);
            end
          end else begin
            state_nxt = ST_AWAIT;
            cy_nxt    = cy_cnt + CX_W'(1);
          end
        end else if (draw_stb) begin
          if (last_sub) begin
            cx_nxt = '0;
            if (last_col) begin
              x_nxt = '0;
              if (last_slot) begin
                state_nxt = ST_LINE_WAIT;
              end else begin
                state_nxt = ST_AWAIT;
                slot_nxt  = slot + I_W'(1);
              end
            end else begin
              state_nxt = ST_DRAW;
              x_nxt     = x_cur + XC_W'(1);
            end
          end else begin
            state_nxt = ST_DRAW;
            x_nxt     = x_cur;
            cx_nxt    = cx_cur + CX_W'(1);
          end
        end else if ((state == ST_AWAIT) && slot_hit) begin
          // Hidden sprite still consumes its slot.
          if (last_slot) state_nxt = ST_LINE_WAIT;
          else           slot_nxt  = slot + I_W'(1);
        end
      end
    endcase

    if (draw_stb) begin
      spr_on_nxt  = pix_bit;
      spr_idx_nxt = pix_bit ? (IDX_W'(slot) + IDX_W'(1)) : '0;
    end else if (pix_en || line_end || (state != ST_DRAW)) begin
      spr_on_nxt  = 1'b0;
      spr_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      slot        <= '0;
      x_cnt       <= '0;
      cx_cnt      <= '0;
      y_cnt       <= '0;
      cy_cnt      <= '0;
      spr_on_p1   <= 1'b0;
      spr_idx_p1  <= '0;
      row_done_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      x_cnt       <= x_nxt;
      cx_cnt      <= cx_nxt;
      y_cnt       <= y_nxt;
      cy_cnt      <= cy_nxt;
      spr_on_p1   <= spr_on_nxt;
      spr_idx_p1  <= spr_idx_nxt;
      row_done_p1 <= row_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      row_x_q <= row_x;
      alive_q <= alive;
      frame_q <= frame_sel;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign spr_on   = spr_on_p1;
  assign spr_idx  = spr_idx_p1;
  assign row_done = row_done_p1;

endmodule

// File: tb/tb_sprite_row_renderer.sv
// Randomised bench: two renderer instances (SCALE 2/PITCH 32 and SCALE 1/PITCH 13)
// share stimulus and are compared every cycle against an arithmetic sprite-row model.
module tb_sprite_row_renderer;

  logic        clk = 1'b0;
  logic        rst, pix_en, line_end, start, frame_sel, wr_en, wr_frame;
  logic [9:0]  pixel_x, row_x;
  logic [10:0] alive;
  logic [2:0]  wr_row;
  logic [12:0] wr_data;
  logic        busy_a, on_a, rd_a, busy_b, on_b, rd_b;
  logic [3:0]  idx_a, idx_b;

  always #5 clk = ~clk;

  sprite_row_renderer #(
    .N_SPR(11), .SPR_W(13), .SPR_H(8), .SCALE(2), .PITCH(32), .X_W(10)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_x(pixel_x), .line_end(line_end),
    .start(start), .row_x(row_x), .alive(alive), .frame_sel(frame_sel),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy_a), .spr_on(on_a), .spr_idx(idx_a), .row_done(rd_a)
  );

  sprite_row_renderer #(
    .N_SPR(11), .SPR_W(13), .SPR_H(8), .SCALE(1), .PITCH(13), .X_W(10)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_x(pixel_x), .line_end(line_end),
    .start(start), .row_x(row_x), .alive(alive), .frame_sel(frame_sel),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy_b), .spr_on(on_b), .spr_idx(idx_b), .row_done(rd_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: bitmap copy plus, per instance, the row being drawn.
  logic [12:0] bm [2][8];
  int          scl [2] = '{2, 1};
  int          pit [2] = '{32, 13};
  bit          act [2];
  int          lc  [2];
  int          rx  [2];
  logic [10:0] alv [2];
  bit          frm [2];
  bit          e_on [2];
  int          e_idx [2];
  bit          e_rd [2];
  int          hitcnt [12];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sprite index (1-based) covering screen pixel px on the current line, or 0.
  function automatic int model_hit(input int d, input int px);
    int off, k, o, col;
    off = px - rx[d];
    if (off < 0) return 0;
    k = off / pit[d];
    o = off % pit[d];
    if (k >= 11 || o >= 13 * scl[d]) return 0;
    if (!alv[d][k]) return 0;
    col = o / scl[d];
    return bm[frm[d]][lc[d] / scl[d]][12 - col] ? k + 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      e_rd[d] = 1'b0;
      if (rst) begin
        act[d] = 1'b0; e_on[d] = 1'b0; e_idx[d] = 0;
      end else if (!act[d]) begin
        e_on[d] = 1'b0; e_idx[d] = 0;
        if (start) begin
          act[d] = 1'b1; lc[d] = 0; rx[d] = int'(row_x); alv[d] = alive; frm[d] = frame_sel;
        end
      end else if (line_end) begin
        e_on[d] = 1'b0; e_idx[d] = 0;
        lc[d]++;
        if (lc[d] == 8 * scl[d]) begin
          act[d] = 1'b0; e_rd[d] = 1'b1;
        end
      end else if (pix_en) begin
        e_idx[d] = model_hit(d, int'(pixel_x));
        e_on[d]  = (e_idx[d] != 0);
      end else begin
        e_on[d] = 1'b0; e_idx[d] = 0;
      end
    end
    if (wr_en) bm[wr_frame][wr_row] = wr_data;
    #1;
    check_val("busy_a", busy_a, act[0]);
    check_val("on_a", on_a, e_on[0]);
    check_val("idx_a", idx_a, e_idx[0]);
    check_val("done_a", rd_a, e_rd[0]);
    check_val("busy_b", busy_b, act[1]);
    check_val("on_b", on_b, e_on[1]);
    check_val("idx_b", idx_b, e_idx[1]);
    check_val("done_b", rd_b, e_rd[1]);
    if (on_a === 1'b1 && idx_a <= 4'd11) hitcnt[idx_a]++;
  endtask

  task automatic write_line(input bit f, input int r, input logic [12:0] data);
    wr_en = 1'b1; wr_frame = f; wr_row = 3'(r); wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rand_bitmap();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 8; r++)
        write_line(f[0], r, (f == 0 && r == 0) ? 13'b0000011110000 : 13'($urandom));
  endtask

  task automatic do_start(input logic [9:0] x, input logic [10:0] a, input bit f);
    row_x = x; alive = a; frame_sel = f;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic run_line(input int len);
    for (int k = 0; k < 12; k++) hitcnt[k] = 0;
    for (int p = 0; p < len; p++) begin
      pix_en = 1'b1; pixel_x = 10'(p);
      step();
    end
    pix_en = 1'b0; line_end = 1'b1;
    step();
    line_end = 1'b0;
    step();
  endtask

  task automatic run_row(input int len);
    for (int l = 0; l < 16; l++) run_line(len);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; line_end = 1'b0; start = 1'b0; frame_sel = 1'b0;
    wr_en = 1'b0; wr_frame = 1'b0; wr_row = '0; wr_data = '0;
    pixel_x = '0; row_x = '0; alive = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Basic row: all alive, known pattern on line 0.
    rand_bitmap();
    do_start(10'd100, 11'h7FF, 1'b0);
    run_line(460);
    check_val("s1_run_idx1", hitcnt[1], 8);
    check_val("s1_run_idx2", hitcnt[2], 8);
    for (int l = 1; l < 16; l++) run_line(460);

    // Sparse alive mask: only sprites 1 and 3.
    do_start(10'd100, 11'b000_0000_0101, 1'b0);
    run_line(460);
    check_val("s2_idx2_none", hitcnt[2], 0);
    check_val("s2_idx3_run", hitcnt[3], 8);
    for (int l = 1; l < 16; l++) run_line(460);

    // Frame latched at start; later frame_sel toggle and start mid-row are ignored.
    for (int r = 0; r < 8; r++) write_line(1'b1, r, 13'h1FFF);
    do_start(10'd100, 11'h7FF, 1'b1);
    for (int l = 0; l < 16; l++) begin
      if (l == 3) begin
        frame_sel = 1'b0; row_x = 10'd50; start = 1'b1;
        step();
        start = 1'b0;
      end
      run_line(460);
      if (l == 5) begin
        check_val("s3_run_idx1", hitcnt[1], 26);
        check_val("s3_run_idx11", hitcnt[11], 26);
      end
    end

    // Early line_end before sprite 7 on every line.
    do_start(10'd100, 11'h7FF, 1'b1);
    for (int l = 0; l < 16; l++) begin
      run_line(290);
      if (l == 2) begin
        check_val("s4_idx6_run", hitcnt[6], 26);
        check_val("s4_idx7_none", hitcnt[7], 0);
      end
    end

    // Slots running off the right edge of the screen.
    rand_bitmap();
    do_start(10'd900, 11'($urandom), 1'($urandom));
    run_row(1024);

    // Asynchronous reset while a sprite pixel is being shown.
    do_start(10'd100, 11'h7FF, 1'b0);
    for (int p = 0; p <= 112; p++) begin
      pix_en = 1'b1; pixel_x = 10'(p);
      step();
    end
    check_val("rst_pre_on", on_a, 1);
    rst = 1'b1;
    #1;
    check_val("rst_on_a", on_a, 0);
    check_val("rst_idx_a", idx_a, 0);
    check_val("rst_busy_a", busy_a, 0);
    check_val("rst_done_a", rd_a, 0);
    check_val("rst_on_b", on_b, 0);
    check_val("rst_busy_b", busy_b, 0);
    pix_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_start(10'd100, 11'h7FF, 1'b0);
    run_row(460);

    // Random rows.
    for (int n = 0; n < 2; n++) begin
      rand_bitmap();
      do_start(10'($urandom_range(0, 150)), 11'($urandom), 1'($urandom));
      run_row($urandom_range(250, 460));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
